// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM port-0 arbiter.
package sram_arb_pkg;
  localparam int SRAM_AW = 9;
  localparam int SRAM_DW = 32;
  localparam int SRAM_MW = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_DATA = 2'd1,
    WB_ACK   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundles the Wishbone slave, core data-RAM and SRAM port-0 signals seen by the arbiter.
interface sram_port_arbiter_if;
  import sram_arb_pkg::*;

  logic               wbs_cyc_i;
  logic               wbs_stb_i;
  logic               wbs_we_i;
  logic [3:0]         wbs_sel_i;
  logic [31:0]        wbs_adr_i;
  logic [31:0]        wbs_dat_i;
  logic               wbs_ack_o;
  logic [31:0]        wbs_dat_o;

  logic               cpu_req_i;
  logic               cpu_we_i;
  logic [SRAM_AW-1:0] cpu_addr_i;
  logic [SRAM_DW-1:0] cpu_wdata_i;
  logic [SRAM_MW-1:0] cpu_wmask_i;
  logic               cpu_gnt_o;
  logic               cpu_rvalid_o;
  logic [SRAM_DW-1:0] cpu_rdata_o;

  logic               ram_csb0_o;
  logic               ram_web0_o;
  logic [SRAM_MW-1:0] ram_wmask0_o;
  logic [SRAM_AW-1:0] ram_addr0_o;
  logic [SRAM_DW-1:0] ram_din0_o;
  logic [SRAM_DW-1:0] ram_dout0_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_wmask_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    output ram_csb0_o, ram_web0_o, ram_wmask0_o, ram_addr0_o, ram_din0_o,
    input  ram_dout0_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_wmask_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    input  ram_csb0_o, ram_web0_o, ram_wmask0_o, ram_addr0_o, ram_din0_o,
    output ram_dout0_i
  );
endinterface

// File: rtl/sram_arb_prio.sv
// Winner select for SRAM port 0: core by default, Wishbone forced after MAX_WAIT lost cycles.
module sram_arb_prio #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic wb_req,
  input  logic wb_hit,
  output logic cpu_win,
  output logic wb_win,
  output logic wb_forced
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt_reg;
  logic          wait_at_max;

  assign wait_at_max = (wait_cnt_reg == CW'(MAX_WAIT));

  // A window miss never touches the SRAM, so it is granted at once; the core
  // loses only that single cycle because the following ack cycle blocks Wishbone.
  // Wins are gated by reset so the macro is deselected the instant reset asserts.
  always_comb begin
    wb_win    = rst_n & wb_req & (~wb_hit | ~cpu_req | wait_at_max);
    cpu_win   = rst_n & cpu_req & ~wb_win;
    wb_forced = wb_win & wb_hit & cpu_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (wb_win) begin
      wait_cnt_reg <= '0;
    end else if (wb_req && wb_hit && cpu_req && !wait_at_max) begin
      wait_cnt_reg <= wait_cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between the Wishbone slave and the core data-RAM interface.
// Define SRAM_ARB_STATS_EN to add the conflict / forced-grant statistics ports.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] WB_BASE     = 32'h3000_0000,
  parameter int          WB_WIN_BITS = 11,
  parameter int          MAX_WAIT    = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  sram_port_arbiter_if.slave   bus
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]          conflict_cnt_o,
  output logic [7:0]           wb_force_cnt_o
`endif
);
  arb_state_t         state_reg;
  logic               wb_rd_reg;
  logic               cpu_rd_reg;
  logic [SRAM_DW-1:0] cpu_rdata_reg;

  logic               wb_req;
  logic               wb_hit;
  logic               cpu_win;
  logic               wb_win;
  logic               wb_forced;
  logic [SRAM_AW-1:0] wb_word;
  logic               unused_adr_bits;

  assign wb_req          = bus.wbs_cyc_i & bus.wbs_stb_i & (state_reg != WB_ACK);
  assign wb_hit          = (bus.wbs_adr_i[31:WB_WIN_BITS] == WB_BASE[31:WB_WIN_BITS]);
  assign wb_word         = bus.wbs_adr_i[SRAM_AW+1:2];
  assign unused_adr_bits = ^bus.wbs_adr_i[1:0];

  sram_arb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .cpu_req   (bus.cpu_req_i),
    .wb_req    (wb_req),
    .wb_hit    (wb_hit),
    .cpu_win   (cpu_win),
    .wb_win    (wb_win),
    .wb_forced (wb_forced)
  );

  always_comb begin
    bus.ram_csb0_o   = 1'b1;
    bus.ram_web0_o   = 1'b1;
    bus.ram_wmask0_o = '0;
    bus.ram_addr0_o  = '0;
    bus.ram_din0_o   = '0;
    if (wb_win && wb_hit) begin
      bus.ram_csb0_o   = 1'b0;
      bus.ram_web0_o   = ~bus.wbs_we_i;
      bus.ram_wmask0_o = bus.wbs_sel_i;
      bus.ram_addr0_o  = wb_word;
      bus.ram_din0_o   = bus.wbs_dat_i;
    end else if (cpu_win) begin
      bus.ram_csb0_o   = 1'b0;
      bus.ram_web0_o   = ~bus.cpu_we_i;
      bus.ram_wmask0_o = bus.cpu_wmask_i;
      bus.ram_addr0_o  = bus.cpu_addr_i;
      bus.ram_din0_o   = bus.cpu_wdata_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg     <= IDLE;
      wb_rd_reg     <= 1'b0;
      cpu_rd_reg    <= 1'b0;
      cpu_rdata_reg <= '0;
    end else begin
      if (state_reg == CPU_DATA && cpu_rd_reg) begin
        cpu_rdata_reg <= bus.ram_dout0_i;
      end
      if (cpu_win) begin
        state_reg  <= CPU_DATA;
        cpu_rd_reg <= ~bus.cpu_we_i;
      end else if (wb_win) begin
        state_reg <= WB_ACK;
        wb_rd_reg <= ~bus.wbs_we_i & wb_hit;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

  // Ack is qualified by cyc so a master that abandoned the cycle never sees it.
  assign bus.wbs_ack_o    = (state_reg == WB_ACK) & bus.wbs_cyc_i;
  assign bus.wbs_dat_o    = (bus.wbs_ack_o && wb_rd_reg) ? bus.ram_dout0_i : '0;
  assign bus.cpu_gnt_o    = cpu_win;
  assign bus.cpu_rvalid_o = (state_reg == CPU_DATA) & cpu_rd_reg;
  assign bus.cpu_rdata_o  = bus.cpu_rvalid_o ? bus.ram_dout0_i : cpu_rdata_reg;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt_reg;
  logic [7:0]  wb_force_cnt_reg;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      conflict_cnt_reg <= '0;
      wb_force_cnt_reg <= '0;
    end else begin
      if (bus.cpu_req_i && wb_req && conflict_cnt_reg != 16'hFFFF) begin
        conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
      end
      if (wb_forced && wb_force_cnt_reg != 8'hFF) begin
        wb_force_cnt_reg <= wb_force_cnt_reg + 8'd1;
      end
    end
  end

  assign conflict_cnt_o = conflict_cnt_reg;
  assign wb_force_cnt_o = wb_force_cnt_reg;
`else
  logic unused_forced;
  assign unused_forced = wb_forced;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM macro and reference memory.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [7:0]  wb_force_cnt;
`endif

  sram_port_arbiter dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
`ifdef SRAM_ARB_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt),
    .wb_force_cnt_o (wb_force_cnt)
`endif
  );

  // Behavioural 1RW macro: captures on the clock edge, read data valid next cycle.
  logic [31:0] sram_mem [512];
  logic [31:0] dout_q = 32'h0;
  assign bus.ram_dout0_i = dout_q;

  always @(posedge clk) begin
    if (!bus.ram_csb0_o) begin
      if (!bus.ram_web0_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_wmask0_o[b]) sram_mem[bus.ram_addr0_o][8*b +: 8] <= bus.ram_din0_o[8*b +: 8];
      end else begin
        dout_q <= sram_mem[bus.ram_addr0_o];
      end
    end
  end

  logic [31:0] ref_mem [512];

  task automatic ref_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wb_op(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat, output int lat,
                       output bit issued, output logic [8:0] iss_addr);
    bit got;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    lat = 0; got = 1'b0; issued = 1'b0; iss_addr = '0; rdat = 32'hx;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!bus.ram_csb0_o && !bus.cpu_gnt_o) begin
        issued = 1'b1;
        iss_addr = bus.ram_addr0_o;
      end
      if (bus.wbs_ack_o) begin
        got = 1'b1;
        rdat = bus.wbs_dat_o;
      end
    end
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
  endtask

  task automatic cpu_op(input bit we, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic [31:0] rd, output bit rv,
                        output int lat);
    bit granted;
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = we; bus.cpu_addr_i = a;
    bus.cpu_wdata_i = d;  bus.cpu_wmask_i = m;
    lat = 0; granted = 1'b0;
    while (!granted && lat < 20) begin
      @(negedge clk);
      lat++;
      granted = bus.cpu_gnt_o;
    end
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    rv = bus.cpu_rvalid_o;
    rd = bus.cpu_rdata_o;
  endtask

  typedef struct {
    bit          is_cpu;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    bit          exp_issue;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rdat, adr, base, dat;
    logic [8:0]  iss_addr, a;
    logic [3:0]  m;
    int          lat, kind;
    bit          issued, rv, we, ack_seen;

    base = 32'h3000_0000;
    for (int i = 0; i < 512; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 9'd3;
    bus.cpu_wdata_i = 0; bus.cpu_wmask_i = 0;

    // Reset state, with a core request pending that must not reach the macro.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    chk("rst_wbdat", bus.wbs_dat_o, 32'd0);
    chk("rst_gnt", {31'b0, bus.cpu_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.cpu_rvalid_o}, 32'd0);
    chk("rst_rdata", bus.cpu_rdata_o, 32'd0);
    chk("rst_csb", {31'b0, bus.ram_csb0_o}, 32'd1);
    chk("rst_web", {31'b0, bus.ram_web0_o}, 32'd1);
    bus.cpu_req_i = 0;
    @(posedge clk); #1 rst_n = 1'b1;

    vecs[0]  = '{0, 1, 32'h3000_0010, 32'hCAFE_BABE, 4'hF, 32'h0,         1};
    vecs[1]  = '{0, 0, 32'h3000_0010, 32'h0,         4'hF, 32'hCAFE_BABE, 1};
    vecs[2]  = '{1, 0, 32'd4,         32'h0,         4'hF, 32'hCAFE_BABE, 1};
    vecs[3]  = '{0, 1, 32'h3000_0010, 32'h0000_AB00, 4'h2, 32'h0,         1};
    vecs[4]  = '{0, 0, 32'h3000_0010, 32'h0,         4'hF, 32'hCAFE_ABBE, 1};
    vecs[5]  = '{0, 0, 32'h3000_0800, 32'h0,         4'hF, 32'h0,         0};
    vecs[6]  = '{0, 1, 32'h3000_0000, 32'h1111_1111, 4'hF, 32'h0,         1};
    vecs[7]  = '{0, 1, 32'h3000_0800, 32'h2222_2222, 4'hF, 32'h0,         0};
    vecs[8]  = '{0, 0, 32'h3000_0000, 32'h0,         4'hF, 32'h1111_1111, 1};
    vecs[9]  = '{1, 1, 32'd5,         32'h5555_5555, 4'hF, 32'h0,         1};
    vecs[10] = '{1, 1, 32'd6,         32'h6666_6666, 4'h9, 32'h0,         1};
    vecs[11] = '{0, 0, 32'h3000_0018, 32'h0,         4'hF, 32'h6600_0066, 1};
    vecs[12] = '{1, 1, 32'd4,         32'hFFFF_FFFF, 4'h4, 32'h0,         1};
    vecs[13] = '{0, 0, 32'h3000_0010, 32'h0,         4'hF, 32'hCAFF_ABBE, 1};

    for (int i = 0; i < 14; i++) begin
      adr = vecs[i].adr;
      if (vecs[i].is_cpu) begin
        cpu_op(vecs[i].we, adr[8:0], vecs[i].dat, vecs[i].mask, rdat, rv, lat);
        $display("TXN vec%0d cpu we=%0d addr=%0d rdata=%h rvalid=%0d lat=%0d",
                 i, vecs[i].we, adr[8:0], rdat, rv, lat);
        chk($sformatf("vec%0d_gnt_lat", i), lat, 1);
        chk($sformatf("vec%0d_rvalid", i), {31'b0, rv}, {31'b0, ~vecs[i].we});
        if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rd);
        else ref_write(adr[8:0], vecs[i].dat, vecs[i].mask);
      end else begin
        wb_op(vecs[i].we, adr, vecs[i].dat, vecs[i].mask, rdat, lat, issued, iss_addr);
        $display("TXN vec%0d wb we=%0d adr=%h dat_o=%h lat=%0d issued=%0d",
                 i, vecs[i].we, adr, rdat, lat, issued);
        chk($sformatf("vec%0d_ack_lat", i), lat, 2);
        chk($sformatf("vec%0d_dat_o", i), rdat, vecs[i].exp_rd);
        chk($sformatf("vec%0d_issued", i), {31'b0, issued}, {31'b0, vecs[i].exp_issue});
        if (vecs[i].exp_issue) begin
          chk($sformatf("vec%0d_iss_addr", i), {23'b0, iss_addr}, {23'b0, adr[10:2]});
          if (vecs[i].we) ref_write(adr[10:2], vecs[i].dat, vecs[i].mask);
        end
      end
    end

    // Back-to-back core reads of words 5 and 6: one grant per cycle.
    @(posedge clk); #1;
    bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 9'd5;
    @(negedge clk);
    chk("b2b_gnt0", {31'b0, bus.cpu_gnt_o}, 32'd1);
    @(posedge clk); #1 bus.cpu_addr_i = 9'd6;
    @(negedge clk);
    chk("b2b_gnt1", {31'b0, bus.cpu_gnt_o}, 32'd1);
    chk("b2b_rvalid0", {31'b0, bus.cpu_rvalid_o}, 32'd1);
    chk("b2b_rdata0", bus.cpu_rdata_o, ref_mem[5]);
    @(posedge clk); #1 bus.cpu_req_i = 0;
    @(negedge clk);
    chk("b2b_rvalid1", {31'b0, bus.cpu_rvalid_o}, 32'd1);
    chk("b2b_rdata1", bus.cpu_rdata_o, ref_mem[6]);
    @(negedge clk);
    chk("b2b_idle_rvalid", {31'b0, bus.cpu_rvalid_o}, 32'd0);
    chk("b2b_rdata_hold", bus.cpu_rdata_o, ref_mem[6]);
    $display("TXN b2b cpu reads 5,6 rdata=%h", bus.cpu_rdata_o);

    // Randomised single-requester traffic against the reference memory.
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      a    = 9'($urandom_range(0, 511));
      dat  = $urandom;
      m    = 4'($urandom_range(0, 15));
      if (kind < 4) begin
        cpu_op(we, a, dat, m, rdat, rv, lat);
        $display("TXN rnd%0d cpu we=%0d addr=%0d mask=%h rdata=%h lat=%0d", i, we, a, m, rdat, lat);
        chk($sformatf("rnd%0d_cpu_lat", i), lat, 1);
        chk($sformatf("rnd%0d_cpu_rvalid", i), {31'b0, rv}, {31'b0, ~we});
        if (we) ref_write(a, dat, m);
        else chk($sformatf("rnd%0d_cpu_rdata", i), rdat, ref_mem[a]);
      end else begin
        if (kind < 9) begin
          adr = base + {21'b0, a, 2'b00};
        end else begin
          adr = $urandom;
          adr[1:0] = 2'b00;
          if (adr[31:11] == base[31:11]) adr[31] = ~adr[31];
        end
        wb_op(we, adr, dat, m, rdat, lat, issued, iss_addr);
        $display("TXN rnd%0d wb we=%0d adr=%h sel=%h dat_o=%h lat=%0d", i, we, adr, m, rdat, lat);
        chk($sformatf("rnd%0d_wb_lat", i), lat, 2);
        chk($sformatf("rnd%0d_wb_issued", i), {31'b0, issued}, {31'b0, kind < 9});
        if (kind < 9 && we) ref_write(a, dat, m);
        chk($sformatf("rnd%0d_wb_dat", i), rdat, (kind < 9 && !we) ? ref_mem[a] : 32'h0);
      end
    end

    // Reset during a Wishbone issue cycle aborts the write and the ack.
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_adr_i = 32'h3000_0010; bus.wbs_dat_i = 32'hDEAD_BEEF; bus.wbs_sel_i = 4'hF;
    #2;
    chk("rstmid_csb_before", {31'b0, bus.ram_csb0_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_csb_now", {31'b0, bus.ram_csb0_o}, 32'd1);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.wbs_ack_o) ack_seen = 1'b1;
    end
    chk("rstmid_no_ack", {31'b0, ack_seen}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef SRAM_ARB_STATS_EN
    chk("stats_conflict_rst", {16'b0, conflict_cnt}, 32'd0);
    chk("stats_force_rst", {24'b0, wb_force_cnt}, 32'd0);
`endif
    wb_op(1'b0, 32'h3000_0010, 32'h0, 4'hF, rdat, lat, issued, iss_addr);
    $display("TXN rstmid wb read adr=30000010 dat_o=%h lat=%0d", rdat, lat);
    chk("rstmid_after_lat", lat, 2);
    chk("rstmid_after_dat", rdat, ref_mem[4]);

    // Core holds its request: Wishbone loses MAX_WAIT cycles, then is forced through.
    @(posedge clk); #1;
    bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 9'd7;
    for (int k = 0; k < 2; k++) begin
      wb_op(1'b0, 32'h3000_0000, 32'h0, 4'hF, rdat, lat, issued, iss_addr);
      $display("TXN contend%0d wb read adr=30000000 dat_o=%h lat=%0d", k, rdat, lat);
      chk($sformatf("contend%0d_lat", k), lat, 4 + 2);
      chk($sformatf("contend%0d_dat", k), rdat, ref_mem[0]);
      chk($sformatf("contend%0d_iss_addr", k), {23'b0, iss_addr}, 32'd0);
    end
    @(negedge clk);
    chk("contend_cpu_gnt", {31'b0, bus.cpu_gnt_o}, 32'd1);
    @(posedge clk); #1 bus.cpu_req_i = 0;
`ifdef SRAM_ARB_STATS_EN
    @(negedge clk);
    chk("stats_conflict", {16'b0, conflict_cnt}, 32'd10);
    chk("stats_force", {24'b0, wb_force_cnt}, 32'd2);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the 1RW port (port 0) of the 2 kB dual-port SRAM macro between the management Wishbone slave and the TMS1x00 core's data-RAM interface.
- Port 1 (read-only program fetch) is not touched by this block.
- Sequences every access as issue cycle plus data cycle, generates the Wishbone ack and the core read-valid, and guarantees forward progress for both requesters.

Parameters:
- WB_BASE, 32'h3000_0000, Wishbone base address of the SRAM window.
- WB_WIN_BITS, 11, log2 of window size in bytes (2 kB).
- MAX_WAIT, 4, cycles a pending Wishbone request may lose arbitration before it is forced to win.

Ports:
- wb_clk_i  in  1  single clock for block and SRAM port 0.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  Wishbone byte selects.
- wbs_adr_i  in  32  Wishbone byte address.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_ack_o  out  1  Wishbone ack.
- wbs_dat_o  out  32  Wishbone read data.
- cpu_req_i  in  1  core access request.
- cpu_we_i  in  1  core write.
- cpu_addr_i  in  9  core word address.
- cpu_wdata_i  in  32  core write data.
- cpu_wmask_i  in  4  core byte mask.
- cpu_gnt_o  out  1  core request accepted this cycle.
- cpu_rvalid_o  out  1  core read data valid.
- cpu_rdata_o  out  32  core read data.
- ram_csb0_o  out  1  SRAM chip select, active low.
- ram_web0_o  out  1  SRAM write enable, active low.
- ram_wmask0_o  out  4  SRAM byte mask.
- ram_addr0_o  out  9  SRAM word address.
- ram_din0_o  out  32  SRAM write data.
- ram_dout0_i  in  32  SRAM read data.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, cpu_gnt_o=0, cpu_rvalid_o=0, cpu_rdata_o=0, ram_csb0_o=1, ram_web0_o=1, wait counter=0, state=IDLE.
- Reset asserted mid-access aborts the access: no ack, no rvalid, csb forced high immediately (asynchronous).
- Wishbone request valid (wb_req) when cyc & stb & state!=WB_ACK.
- Window hit when wbs_adr_i[31:WB_WIN_BITS]==WB_BASE[31:WB_WIN_BITS]. SRAM word address = wbs_adr_i[10:2].
- Issue cycle N: ram_* outputs are combinational from the winner. csb0=0; web0=~we; wmask = sel or cpu_wmask; din = the winner's write data.
- Macro captures on the edge ending N; ram_dout0_i is valid during N+1.
- Arbitration:
  - cpu_req wins by default.
  - The wait counter increments each cycle a wb_req (hit) loses, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, Wishbone wins. The counter clears on Wishbone grant.
  - cpu_gnt_o=1 in the issue cycle only; the core must hold its request until granted.
- States:
  - IDLE → WB_ACK on Wishbone grant.
  - IDLE → CPU_DATA on CPU grant.
  - CPU_DATA: cpu_rvalid_o=1 if the access was a read, cpu_rdata_o=ram_dout0_i (registered capture of the data-cycle value held until next read). A new grant of either requester may issue in the same cycle (back-to-back).
  - WB_ACK: wbs_ack_o=1 for exactly one cycle; wbs_dat_o=ram_dout0_i for reads, 0 for writes. Wishbone is blocked this cycle (master drops stb), CPU may issue.
  - Return to IDLE (or issue state) next cycle.
- Window miss: no SRAM access. Ack asserted the next cycle with wbs_dat_o=0; writes discarded. Prevents bus hang.
- cyc dropped before ack: the issued access still completes in the SRAM; ack is suppressed.
- Simultaneous CPU and Wishbone request with counter<MAX_WAIT: CPU granted and Wishbone counter increments.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- When defined:
  - Adds output port conflict_cnt_o (16 bits), a saturating count of cycles in which both requesters were pending and one lost.
  - Adds output port wb_force_cnt_o (8 bits), a saturating count of MAX_WAIT-forced grants.
  - Both counters clear on reset.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg holds the state enum (IDLE, CPU_DATA, WB_ACK), SRAM_AW=9, SRAM_DW=32, SRAM_MW=4.
- One sub-module, sram_arb_prio: combinational winner select plus the wait counter (the only sequential state it owns).
- FSM and data capture stay in the top module.

Test Plan:
- Wishbone write 0x3000_0010 data 0xCAFEBABE sel 4'hF, then read the same address → write ack one cycle after issue. Read ack in cycle N+1 with wbs_dat_o=0xCAFEBABE; ram_addr0_o=9'd4 at issue.
- Core read addr 9'd4 with no Wishbone traffic → cpu_gnt_o in cycle N, cpu_rvalid_o=1 and cpu_rdata_o=0xCAFEBABE in N+1. Back-to-back reads of 5 and 6 → one grant per cycle.
- Core holds cpu_req_i continuously while Wishbone reads 0x3000_0000 → Wishbone loses 4 cycles, granted on cycle 5, ack on cycle 6; counter returns to 0.
- Wishbone read of 0x3000_0800 (outside the window) → ack next cycle, wbs_dat_o=0, ram_csb0_o stays 1.
- Sel 4'b0010 write of 0x0000AB00 over 0xCAFEBABE, then read → 0xCAFEABBE.
- Assert wb_rst_n_i low during the WB_ACK-pending issue cycle → ack never asserted, ram_csb0_o=1 immediately. After release, first access behaves normally. With SRAM_ARB_STATS_EN, conflict_cnt_o=0 after reset.
